// File: rtl/route_reservation_allocator.sv
// Route reservation allocator: each router output is granted to one input at a time,
// round-robin among eligible requesters, and held until the owning input relieves it.
module route_reservation_lane #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] elig_i,
  input  logic [N-1:0] relieve_i,
  output logic         busy_o,
  output logic [W-1:0] owner_o,
  output logic [N-1:0] gnt_o
);
  typedef enum logic {FREE, BUSY} state_e;

  state_e       state_q;
  logic [W-1:0] owner_q, rr_q, pick_d, rr_d;
  logic         found;
  int           idx, nxt;

  // Scan rr_q, rr_q+1, ... modulo N for the first eligible input.
  always_comb begin
    found  = 1'b0;
    pick_d = '0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && elig_i[idx]) begin
        found  = 1'b1;
        pick_d = W'(idx);
      end
    end
    nxt = int'(pick_d) + 1;
    if (nxt >= N) nxt = 0;
    rr_d  = W'(nxt);
    gnt_o = '0;
    if (state_q == FREE && found) gnt_o[pick_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FREE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      case (state_q)
        FREE: if (found) begin
          state_q <= BUSY;
          owner_q <= pick_d;
          rr_q    <= rr_d;
        end
        BUSY: if (relieve_i[owner_q]) state_q <= FREE;
        default: state_q <= FREE;
      endcase
    end
  end

  assign busy_o  = (state_q == BUSY);
  assign owner_o = owner_q;
endmodule

module route_reservation_allocator #(
  parameter int N             = 4,
  parameter int REQUEST_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               routeReserveRequestValid,
  input  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest,
  input  logic [N-1:0]               routeRelieve,
  output logic [N-1:0]               routeReserveStatus,
  output logic [N-1:0]               outputBusy,
  output logic [N*REQUEST_WIDTH-1:0] outputSelect
);
  localparam int W = REQUEST_WIDTH;

  logic [N-1:0][N-1:0] elig, gnt;  // [output][input]
  logic [N-1:0]        status_q, status_d, gnt_any;

  for (genvar o = 0; o < N; o++) begin : g_out
    for (genvar i = 0; i < N; i++) begin : g_in
      // An input that already holds an output is never a candidate.
      assign elig[o][i] = routeReserveRequestValid[i] && !status_q[i] &&
                          (routeReserveRequest[i*W +: W] == W'(o));
    end
    route_reservation_lane #(.N(N), .W(W)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .elig_i    (elig[o]),
      .relieve_i (routeRelieve),
      .busy_o    (outputBusy[o]),
      .owner_o   (outputSelect[o*W +: W]),
      .gnt_o     (gnt[o])
    );
  end

  // Grants only target inputs with status 0, so set and clear never collide.
  always_comb begin
    gnt_any = '0;
    for (int o = 0; o < N; o++) gnt_any = gnt_any | gnt[o];
    status_d = (status_q & ~routeRelieve) | gnt_any;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) status_q <= '0;
    else      status_q <= status_d;
  end

  assign routeReserveStatus = status_q;
endmodule
